// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin CPU/DMA arbiter that sequences one main-memory
// bus transaction at a time (address, wait states, strobe, ack).
module mem_bus_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic          mem_clk,
   output logic          busy,
   output logic          grant
);
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_STROBE, S_DONE} state_t;
   state_t        r_state, w_next;
   logic [3:0]    r_cnt;
   logic          r_last, r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata, r_rdata;
   logic          w_pick_dma, w_act, w_done;
   // r_last doubles as the current grant: it is updated at the moment of granting
   assign w_pick_dma = dma_req & (~cpu_req | ~r_last);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && (cpu_req || dma_req)) begin
            r_last  <= w_pick_dma;
            r_we    <= w_pick_dma ? dma_we : cpu_we;
            r_addr  <= w_pick_dma ? dma_addr : cpu_addr;
            r_wdata <= w_pick_dma ? dma_wdata : cpu_wdata;
         end
         if (r_state == S_ADDR) r_cnt <= 4'(WAIT_STATES);
         else if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
         if (r_state == S_STROBE && !r_we) r_rdata <= mem_rdata;
      end
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = (cpu_req || dma_req) ? S_ADDR : S_IDLE;
         S_ADDR:   w_next = (WAIT_STATES == 0) ? S_STROBE : S_WAIT;
         S_WAIT:   w_next = (r_cnt == 4'd1) ? S_STROBE : S_WAIT;
         S_STROBE: w_next = S_DONE;
         default:  w_next = S_IDLE;
      endcase
   end
   // all bus outputs decode from registers only, so no req-to-bus path exists
   assign busy      = r_state != S_IDLE;
   assign grant     = busy & r_last;
   assign w_act     = busy & (r_state != S_DONE);
   assign w_done    = r_state == S_DONE;
   assign mem_addr  = busy ? r_addr : '0;
   assign mem_wdata = busy ? r_wdata : '0;
   assign mem_rd    = w_act & ~r_we;
   assign mem_wr    = w_act & r_we;
   assign mem_clk   = r_state == S_STROBE;
   assign cpu_ack   = w_done & ~r_last;
   assign dma_ack   = w_done & r_last;
   assign cpu_rdata = (cpu_ack & ~r_we) ? r_rdata : '0;
   assign dma_rdata = (dma_ack & ~r_we) ? r_rdata : '0;
endmodule
